// File: rtl/pmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmu_pkg
// Description : Shared types and helpers for the PMU register-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pmu_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } pmu_arb_state_e;

    localparam int PMU_REG_WIDTH = 32;

    // Index width for n items; never returns 0 so 1-entry vectors stay legal.
    function automatic int pmu_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : pmu_rr_picker
// Description : Combinational round-robin picker; first valid from ptr_i up.
// Revision    : 1.0 - initial release
// ============================================================================
module pmu_rr_picker
    import pmu_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = pmu_idx_w(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               cand_int;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand_int = int'(ptr_i) + k;
            if (cand_int >= N) begin
                cand_int = cand_int - N;
            end
            cand = IDX_W'(cand_int);
            if (!found && valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
        any_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/pmu_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmu_reg_arbiter
// Description : Round-robin, lockable arbiter sharing the PMU register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module pmu_reg_arbiter
    import pmu_pkg::*;
#(
    parameter  int N_REQ     = 2,
    parameter  int N_REGS    = 10,
    parameter  int REG_WIDTH = PMU_REG_WIDTH,
    parameter  int LOCK_MAX  = 16,
    localparam int ADDR_W    = pmu_idx_w(N_REGS)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ-1:0]           req_we_i,
    input  logic [N_REQ-1:0]           req_lock_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*REG_WIDTH-1:0] req_wdata_i,
    output logic [N_REQ-1:0]           rsp_valid_o,
    output logic [N_REQ-1:0]           rsp_err_o,
    output logic [N_REQ*REG_WIDTH-1:0] rsp_rdata_o,
    output logic                       bank_we_o,
    output logic [ADDR_W-1:0]          bank_addr_o,
    output logic [REG_WIDTH-1:0]       bank_wdata_o,
    input  logic [REG_WIDTH-1:0]       bank_rdata_i
);

    localparam int                 REQ_W        = pmu_idx_w(N_REQ);
    localparam int                 CNT_W        = pmu_idx_w(LOCK_MAX + 1);
    localparam logic [ADDR_W-1:0]  LAST_IDX     = ADDR_W'(N_REGS - 1);
    localparam logic [REQ_W-1:0]   LAST_REQ     = REQ_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]   LOCK_CNT_MAX = CNT_W'(LOCK_MAX);

    pmu_arb_state_e             state_q, state_d;
    logic [REQ_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0]           owner_q, owner_d;
    logic [CNT_W-1:0]           lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0]           rsp_err_q, rsp_err_d;
    logic [N_REQ*REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [N_REQ-1:0] owner_mask;
    logic [N_REQ-1:0] cand_valid;
    logic [N_REQ-1:0] pick_grant;
    logic [REQ_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic             win_we;
    logic             win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic             win_in_range;

    function automatic logic [REQ_W-1:0] ptr_after(input logic [REQ_W-1:0] idx);
        return (idx == LAST_REQ) ? '0 : idx + 1'b1;
    endfunction

    // While locked, the picker only ever sees the owner's request.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        cand_valid          = (state_q == LOCKED) ? (req_valid_i & owner_mask) : req_valid_i;
    end

    pmu_rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .valid_i (cand_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign accept       = pick_any & rstn_i;
    assign win_we       = req_we_i[pick_idx];
    assign win_lock     = req_lock_i[pick_idx];
    assign win_addr     = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign win_in_range = (win_addr <= LAST_IDX);

    assign req_ready_o  = rstn_i ? pick_grant : '0;
    assign bank_we_o    = accept & win_we & win_in_range;
    assign bank_addr_o  = win_addr;
    assign bank_wdata_o = req_wdata_i[int'(pick_idx)*REG_WIDTH +: REG_WIDTH];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        lock_cnt_d  = lock_cnt_q;
        rsp_valid_d = '0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept) begin
            rr_ptr_d              = ptr_after(pick_idx);
            rsp_valid_d[pick_idx] = 1'b1;
            rsp_err_d[pick_idx]   = ~win_in_range;
            if (!win_we) begin
                rsp_rdata_d[int'(pick_idx)*REG_WIDTH +: REG_WIDTH] =
                    win_in_range ? bank_rdata_i : '0;
            end
        end

        case (state_q)
            ARB: begin
                if (accept && win_lock) begin
                    state_d    = LOCKED;
                    owner_d    = pick_idx;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            LOCKED: begin
                // Timeout still lets this cycle's owner access through.
                if (!req_valid_i[owner_q] || (accept && !win_lock) ||
                    (lock_cnt_q == LOCK_CNT_MAX)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    rr_ptr_d   = ptr_after(owner_q);
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(req_ready_o));

    a_we_legal: assert property (@(posedge clk_i) disable iff (!rstn_i)
        bank_we_o |-> ((|(req_ready_o & req_we_i)) && (bank_addr_o <= LAST_IDX)));

endmodule
`default_nettype wire

// File: tb/tb_pmu_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmu_reg_arbiter
// Description : Self-checking bench for pmu_reg_arbiter against a queue-free
//               behavioural model of grant, lock and response rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmu_reg_arbiter;

    localparam int N_REQ    = 2;
    localparam int N_REGS   = 10;
    localparam int RW       = 32;
    localparam int LOCK_MAX = 4;
    localparam int AW       = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]    valid, we, lock;
    logic [AW-1:0]       addr  [N_REQ];
    logic [RW-1:0]       wdata [N_REQ];
    logic [N_REQ*AW-1:0] p_addr;
    logic [N_REQ*RW-1:0] p_wdata;

    logic [N_REQ-1:0]    req_ready_o, rsp_valid_o, rsp_err_o;
    logic [N_REQ*RW-1:0] rsp_rdata_o;
    logic                bank_we_o;
    logic [AW-1:0]       bank_addr_o;
    logic [RW-1:0]       bank_wdata_o;
    logic [RW-1:0]       bank_rdata_i;

    // Register bank emulation: 16 entries so out-of-range indices return junk.
    logic [RW-1:0] bank [16];
    assign bank_rdata_i = bank[bank_addr_o];

    always_comb begin
        p_addr  = '0;
        p_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            p_addr[i*AW +: AW]  = addr[i];
            p_wdata[i*RW +: RW] = wdata[i];
        end
    end

    pmu_reg_arbiter #(
        .N_REQ     (N_REQ),
        .N_REGS    (N_REGS),
        .REG_WIDTH (RW),
        .LOCK_MAX  (LOCK_MAX)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (valid),
        .req_ready_o  (req_ready_o),
        .req_we_i     (we),
        .req_lock_i   (lock),
        .req_addr_i   (p_addr),
        .req_wdata_i  (p_wdata),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .bank_we_o    (bank_we_o),
        .bank_addr_o  (bank_addr_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_rdata_i (bank_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state: pointer, lock owner (-1 = none), lock age, bank image.
    int            rr, owner, age, m_win;
    logic [RW-1:0] mem     [N_REGS];
    bit            e_valid [N_REQ];
    bit            e_err   [N_REQ];
    logic [RW-1:0] e_rdata [N_REQ];

    // Values observed at the last compare point.
    logic [N_REQ-1:0] s_ready, s_rsp_valid, s_rsp_err;
    logic             s_bank_we;
    logic [AW-1:0]    s_bank_addr;
    logic [RW-1:0]    s_bank_wdata;
    logic [RW-1:0]    s_rdata [N_REQ];
    int               we_pulses;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rr    = 0;
        owner = -1;
        age   = 0;
        m_win = -1;
        for (int i = 0; i < N_REQ; i++) begin
            e_valid[i] = 1'b0;
            e_err[i]   = 1'b0;
            e_rdata[i] = '0;
        end
    endtask

    task automatic model_compare();
        int               j;
        logic [N_REQ-1:0] exp_ready;
        bit               exp_we;
        if (!rstn) model_reset();
        m_win = -1;
        if (rstn) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = (rr + k) % N_REQ;
                if (m_win < 0 && valid[j] && (owner < 0 || owner == j)) m_win = j;
            end
        end
        exp_ready = '0;
        if (m_win >= 0) exp_ready[m_win] = 1'b1;
        exp_we = (m_win >= 0) && we[m_win] && (int'(addr[m_win]) < N_REGS);
        check("ready", req_ready_o, exp_ready);
        check("bank_we", bank_we_o, exp_we);
        if (m_win >= 0) check("bank_addr", bank_addr_o, addr[m_win]);
        if (exp_we)     check("bank_wdata", bank_wdata_o, wdata[m_win]);
        for (int i = 0; i < N_REQ; i++) begin
            check($sformatf("rsp_valid[%0d]", i), rsp_valid_o[i], e_valid[i]);
            if (e_valid[i]) check($sformatf("rsp_err[%0d]", i), rsp_err_o[i], e_err[i]);
            check($sformatf("rsp_rdata[%0d]", i), rsp_rdata_o[i*RW +: RW], e_rdata[i]);
            s_rdata[i] = rsp_rdata_o[i*RW +: RW];
        end
        s_ready      = req_ready_o;
        s_rsp_valid  = rsp_valid_o;
        s_rsp_err    = rsp_err_o;
        s_bank_we    = bank_we_o;
        s_bank_addr  = bank_addr_o;
        s_bank_wdata = bank_wdata_o;
    endtask

    task automatic model_update();
        int  w;
        bit  in_rng;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (s_bank_we) bank[s_bank_addr] = s_bank_wdata;
        for (int i = 0; i < N_REQ; i++) e_valid[i] = 1'b0;
        if (m_win >= 0) begin
            w          = m_win;
            in_rng     = int'(addr[w]) < N_REGS;
            e_valid[w] = 1'b1;
            e_err[w]   = !in_rng;
            if (!we[w])      e_rdata[w] = in_rng ? mem[addr[w]] : '0;
            else if (in_rng) mem[addr[w]] = wdata[w];
        end
        if (owner < 0) begin
            if (m_win >= 0) begin
                rr = (m_win + 1) % N_REQ;
                if (lock[m_win]) begin
                    owner = m_win;
                    age   = 1;
                end
            end
        end else begin
            rr = (owner + 1) % N_REQ;
            if (!valid[owner] || !lock[owner] || age == LOCK_MAX) begin
                owner = -1;
                age   = 0;
            end else begin
                age++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int i, input bit v, input bit w, input bit l,
                         input int a, input logic [RW-1:0] d);
        valid[i] = v;
        we[i]    = w;
        lock[i]  = l;
        addr[i]  = AW'(a);
        wdata[i] = d;
    endtask

    initial begin
        rstn  = 1'b1;
        valid = '0;
        we    = '0;
        lock  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        for (int i = 0; i < 16; i++)     bank[i] = 32'hA5A5_0000 | RW'(i);
        for (int i = 0; i < N_REGS; i++) mem[i]  = 32'hA5A5_0000 | RW'(i);
        model_reset();
        #1 rstn = 1'b0;

        // Reset with both requesters pending, then release.
        drive(0, 1, 0, 0, 3, 0);
        drive(1, 1, 0, 0, 5, 0);
        repeat (3) step();
        check("rst_ready", s_ready, 0);
        check("rst_bank_we", s_bank_we, 0);
        check("rst_rsp_valid", s_rsp_valid, 0);
        rstn = 1'b1;
        step();
        check("first_grant_req0", s_ready, 2'b01);

        // Alternating grants with one-cycle read responses.
        step();
        check("alt_grant_1", s_ready, 2'b10);
        check("alt_rsp_valid_0", s_rsp_valid, 2'b01);
        check("alt_rdata0_idx3", s_rdata[0], 32'hA5A5_0003);
        step();
        check("alt_grant_0", s_ready, 2'b01);
        check("alt_rsp_valid_1", s_rsp_valid, 2'b10);
        check("alt_rdata1_idx5", s_rdata[1], 32'hA5A5_0005);
        step();
        check("alt_grant_1b", s_ready, 2'b10);
        valid = '0;
        step();
        check("alt_last_rsp", s_rsp_valid, 2'b10);

        // Write then read back.
        we_pulses = 0;
        drive(0, 1, 1, 0, 2, 32'hDEAD_BEEF);
        step();
        we_pulses += int'(s_bank_we);
        check("wr_bank_we", s_bank_we, 1'b1);
        drive(0, 1, 0, 0, 2, 0);
        step();
        we_pulses += int'(s_bank_we);
        valid = '0;
        step();
        we_pulses += int'(s_bank_we);
        check("rd_back_valid", s_rsp_valid, 2'b01);
        check("rd_back_data", s_rdata[0], 32'hDEAD_BEEF);
        check("rd_back_err", s_rsp_err[0], 1'b0);
        check("wr_we_pulses", we_pulses, 1);

        // Out-of-range read and write.
        drive(1, 1, 0, 0, 12, 0);
        step();
        drive(1, 1, 1, 0, 15, 32'h1234_5678);
        step();
        check("oor_wr_no_we", s_bank_we, 1'b0);
        check("oor_rd_valid", s_rsp_valid, 2'b10);
        check("oor_rd_err", s_rsp_err[1], 1'b1);
        check("oor_rd_zero", s_rdata[1], 0);
        valid = '0;
        step();
        check("oor_wr_valid", s_rsp_valid, 2'b10);
        check("oor_wr_err", s_rsp_err[1], 1'b1);
        check("oor_wr_rdata_held", s_rdata[1], 0);

        // Locked sequence released by an unlocked owner access.
        drive(1, 1, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 4, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("lock_hold_%0d", k), s_ready, 2'b01);
        end
        lock[0] = 1'b0;
        step();
        check("lock_release_access", s_ready, 2'b01);
        step();
        check("lock_release_req1", s_ready, 2'b10);

        // Lock timeout: owner keeps lock=1, loses the bus after LOCK_MAX locked cycles.
        drive(0, 1, 0, 1, 6, 0);
        drive(1, 1, 0, 0, 7, 0);
        for (int k = 0; k < LOCK_MAX + 1; k++) begin
            step();
            check($sformatf("timeout_hold_%0d", k), s_ready, 2'b01);
        end
        step();
        check("timeout_handover", s_ready, 2'b10);
        valid = '0;
        step();

        // Asynchronous reset in the middle of a locked sequence.
        drive(0, 1, 1, 1, 8, 32'hCAFE_F00D);
        drive(1, 1, 0, 0, 9, 0);
        step();
        step();
        rstn = 1'b0;
        #1;
        check("async_rst_ready", req_ready_o, 0);
        check("async_rst_rsp", rsp_valid_o, 0);
        lock[0] = 1'b0;
        we[0]   = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("post_rst_grant0", s_ready, 2'b01);
        step();
        check("post_rst_no_lock", s_ready, 2'b10);

        // Randomised traffic.
        repeat (400) begin
            for (int i = 0; i < N_REQ; i++) begin
                drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, int'($urandom_range(0, 13)), $urandom);
            end
            step();
        end
        valid = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
